// File: rtl/s2mm_burst_ctrl.sv
// S2MM command sequencer: splits buffer descriptors into 4 KiB-safe AXI write bursts and reports committed bytes.
// Define S2MM_BURST_CTRL_DESC_CHECK_EN to reject malformed descriptors with sts_err instead of truncating them.
module s2mm_burst_ctrl #(
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      desc_addr,
    input  logic [LEN_W-1:0] desc_len,
    input  logic             desc_valid,
    output logic             desc_ready,
    output logic [31:0]      cmd_addr,
    output logic [7:0]       cmd_len,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    input  logic             beat_done,
    input  logic [2:0]       beat_bytes,
    input  logic             beat_eop,
    input  logic             burst_done,
    output logic [LEN_W-1:0] sts_bytes,
    output logic             sts_eop,
    output logic             sts_err,
    output logic             sts_valid,
    input  logic             sts_ready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_WAIT,
        ST_STATUS
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] rem_words_q, rem_words_d;
    logic [8:0]       beats_q, beats_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             eop_seen_q, eop_seen_d;
    logic             err_q, err_d;
    logic             desc_ready_q, desc_ready_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [31:0]      cmd_addr_q, cmd_addr_d;
    logic [7:0]       cmd_len_q, cmd_len_d;
    logic             sts_valid_q, sts_valid_d;

    logic [12:0]      page_bytes;
    logic [31:0]      page_words;
    logic [31:0]      rem_words_ext;
    logic [31:0]      beats_min;
    logic [8:0]       beats_calc;
    logic [LEN_W:0]   byte_sum;
    logic             desc_bad;

`ifdef S2MM_BURST_CTRL_DESC_CHECK_EN
    assign desc_bad = (desc_len == '0) || (desc_len[1:0] != 2'b00) || (desc_addr[1:0] != 2'b00);
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^desc_addr[1:0];
    assign desc_bad         = 1'b0;
`endif

    // Burst size is the tightest of the beat cap, the words left, and the words left before the 4 KiB page ends.
    always_comb begin
        page_bytes    = 13'h1000 - {1'b0, addr_q[11:0]};
        page_words    = {21'd0, page_bytes[12:2]};
        rem_words_ext = 32'(rem_words_q);
        beats_min     = 32'(MAX_BURST);
        if (rem_words_ext < beats_min) begin
            beats_min = rem_words_ext;
        end
        if (page_words < beats_min) begin
            beats_min = page_words;
        end
        beats_calc = 9'(beats_min);
    end

    assign byte_sum = {1'b0, byte_cnt_q} + (LEN_W+1)'(beat_bytes);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_words_d = rem_words_q;
        beats_d     = beats_q;
        byte_cnt_d  = byte_cnt_q;
        eop_seen_d  = eop_seen_q;
        err_d       = err_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;

        case (state_q)
            ST_IDLE: begin
                if (desc_ready_q && desc_valid) begin
                    addr_d      = {desc_addr[31:2], 2'b00};
                    rem_words_d = desc_len >> 2;
                    byte_cnt_d  = '0;
                    eop_seen_d  = 1'b0;
                    err_d       = desc_bad;
                    state_d     = desc_bad ? ST_STATUS : ST_CALC;
                end
            end
            ST_CALC: begin
                if (rem_words_q == '0) begin
                    state_d = ST_STATUS;
                end else begin
                    beats_d    = beats_calc;
                    cmd_addr_d = addr_q;
                    cmd_len_d  = 8'(beats_calc - 9'd1);
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_valid_q && cmd_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (beat_done) begin
                    byte_cnt_d = byte_sum[LEN_W] ? '1 : byte_sum[LEN_W-1:0];
                    if (beat_eop) begin
                        eop_seen_d = 1'b1;
                    end
                end
                // An eop on the wlast beat itself still ends the buffer, hence eop_seen_d rather than _q.
                if (burst_done) begin
                    addr_d      = addr_q + 32'({beats_q, 2'b00});
                    rem_words_d = rem_words_q - LEN_W'(beats_q);
                    state_d     = (eop_seen_d || (rem_words_q == LEN_W'(beats_q))) ? ST_STATUS : ST_CALC;
                end
            end
            ST_STATUS: begin
                if (sts_valid_q && sts_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        desc_ready_d = (state_d == ST_IDLE);
        cmd_valid_d  = (state_d == ST_ISSUE);
        sts_valid_d  = (state_d == ST_STATUS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rem_words_q  <= '0;
            beats_q      <= '0;
            byte_cnt_q   <= '0;
            eop_seen_q   <= 1'b0;
            err_q        <= 1'b0;
            desc_ready_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            sts_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_words_q  <= rem_words_d;
            beats_q      <= beats_d;
            byte_cnt_q   <= byte_cnt_d;
            eop_seen_q   <= eop_seen_d;
            err_q        <= err_d;
            desc_ready_q <= desc_ready_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_len_q    <= cmd_len_d;
            sts_valid_q  <= sts_valid_d;
        end
    end

    assign desc_ready = desc_ready_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_len    = cmd_len_q;
    assign sts_valid  = sts_valid_q;
    assign sts_bytes  = byte_cnt_q;
    assign sts_eop    = eop_seen_q;
    assign sts_err    = err_q;

endmodule

// File: tb/tb_s2mm_burst_ctrl.sv
// Scoreboard bench for s2mm_burst_ctrl: directed descriptors push expected commands/status, a monitor pops on handshakes.
// Honours S2MM_BURST_CTRL_DESC_CHECK_EN for the malformed-descriptor cases.
module tb_s2mm_burst_ctrl;

    localparam int LEN_W = 24;

    logic             clk;
    logic             rst_n;
    logic [31:0]      desc_addr;
    logic [LEN_W-1:0] desc_len;
    logic             desc_valid;
    logic             desc_ready;
    logic [31:0]      cmd_addr;
    logic [7:0]       cmd_len;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             beat_done;
    logic [2:0]       beat_bytes;
    logic             beat_eop;
    logic             burst_done;
    logic [LEN_W-1:0] sts_bytes;
    logic             sts_eop;
    logic             sts_err;
    logic             sts_valid;
    logic             sts_ready;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } cmdExp_t;

    typedef struct packed {
        logic [LEN_W-1:0] bytes;
        logic             eop;
        logic             err;
    } stsExp_t;

    cmdExp_t expCmdQ[$];
    stsExp_t expStsQ[$];
    int      testsRun    = 0;
    int      testsFailed = 0;

    s2mm_burst_ctrl #(.MAX_BURST(16), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .desc_addr  (desc_addr),
        .desc_len   (desc_len),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .beat_done  (beat_done),
        .beat_bytes (beat_bytes),
        .beat_eop   (beat_eop),
        .burst_done (burst_done),
        .sts_bytes  (sts_bytes),
        .sts_eop    (sts_eop),
        .sts_err    (sts_err),
        .sts_valid  (sts_valid),
        .sts_ready  (sts_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectCmd(input logic [31:0] addr, input logic [7:0] len);
        cmdExp_t e;
        e.addr = addr;
        e.len  = len;
        expCmdQ.push_back(e);
    endtask

    task automatic expectSts(input logic [LEN_W-1:0] bytes, input logic eop, input logic err);
        stsExp_t e;
        e.bytes = bytes;
        e.eop   = eop;
        e.err   = err;
        expStsQ.push_back(e);
    endtask

    // Pops the scoreboard whenever a command or status handshake is about to complete.
    task automatic monitorLoop();
        cmdExp_t c;
        stsExp_t s;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_valid && cmd_ready) begin
                if (expCmdQ.size() == 0) begin
                    checkOutput("cmd_unexpected", 64'd1, 64'd0);
                end else begin
                    c = expCmdQ.pop_front();
                    checkOutput("cmd_addr", 64'(cmd_addr), 64'(c.addr));
                    checkOutput("cmd_len", 64'(cmd_len), 64'(c.len));
                end
            end
            if (rst_n && sts_valid && sts_ready) begin
                if (expStsQ.size() == 0) begin
                    checkOutput("sts_unexpected", 64'd1, 64'd0);
                end else begin
                    s = expStsQ.pop_front();
                    checkOutput("sts_bytes", 64'(sts_bytes), 64'(s.bytes));
                    checkOutput("sts_eop", 64'(sts_eop), 64'(s.eop));
                    checkOutput("sts_err", 64'(sts_err), 64'(s.err));
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [LEN_W-1:0] len);
        int waitCnt = 0;
        while (!desc_ready && waitCnt < 200) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (!desc_ready) begin
            checkOutput("desc_ready_timeout", 64'(desc_ready), 64'd1);
            return;
        end
        desc_addr  = addr;
        desc_len   = len;
        desc_valid = 1'b1;
        @(posedge clk);
        #1;
        desc_valid = 1'b0;
        checkOutput("desc_ready_drop", 64'(desc_ready), 64'd0);
    endtask

    task automatic acceptCmd(input int stall, input logic [31:0] stallAddr, input logic [7:0] stallLen,
                             output bit ok);
        int waitCnt = 0;
        ok = 1'b0;
        while (!cmd_valid && waitCnt < 200) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (!cmd_valid) begin
            checkOutput("cmd_timeout", 64'(cmd_valid), 64'd1);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            checkOutput("stall_cmd_valid", 64'(cmd_valid), 64'd1);
            checkOutput("stall_cmd_addr", 64'(cmd_addr), 64'(stallAddr));
            checkOutput("stall_cmd_len", 64'(cmd_len), 64'(stallLen));
            checkOutput("stall_desc_ready", 64'(desc_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        ok = 1'b1;
    endtask

    // eopBeat==0 means no tlast in this burst; beats after the eop beat are zero-byte pads.
    task automatic serveBurst(input int beats, input int eopBeat, input int eopBytes, input int stall,
                              input logic [31:0] stallAddr, input logic [7:0] stallLen);
        bit ok;
        int nBytes;
        acceptCmd(stall, stallAddr, stallLen, ok);
        if (!ok) return;
        for (int b = 1; b <= beats; b++) begin
            if (eopBeat == 0 || b < eopBeat) nBytes = 4;
            else if (b == eopBeat)           nBytes = eopBytes;
            else                             nBytes = 0;
            beat_done  = 1'b1;
            beat_bytes = 3'(nBytes);
            beat_eop   = (b == eopBeat);
            burst_done = (b == beats);
            @(posedge clk);
            #1;
        end
        beat_done  = 1'b0;
        beat_bytes = 3'd0;
        beat_eop   = 1'b0;
        burst_done = 1'b0;
    endtask

    task automatic waitStatus(input int stall, input logic [LEN_W-1:0] stallBytes, input logic stallEop);
        int waitCnt = 0;
        while (!sts_valid && waitCnt < 200) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (!sts_valid) begin
            checkOutput("sts_timeout", 64'(sts_valid), 64'd1);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            checkOutput("stall_sts_valid", 64'(sts_valid), 64'd1);
            checkOutput("stall_sts_bytes", 64'(sts_bytes), 64'(stallBytes));
            checkOutput("stall_sts_eop", 64'(sts_eop), 64'(stallEop));
            checkOutput("stall_sts_desc_ready", 64'(desc_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        sts_ready = 1'b1;
        @(posedge clk);
        #1;
        sts_ready = 1'b0;
        checkOutput("desc_ready_after_sts", 64'(desc_ready), 64'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        desc_addr  = '0;
        desc_len   = '0;
        desc_valid = 1'b0;
        cmd_ready  = 1'b0;
        beat_done  = 1'b0;
        beat_bytes = 3'd0;
        beat_eop   = 1'b0;
        burst_done = 1'b0;
        sts_ready  = 1'b0;

        fork
            monitorLoop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_desc_ready", 64'(desc_ready), 64'd0);
        checkOutput("reset_cmd_valid", 64'(cmd_valid), 64'd0);
        checkOutput("reset_sts_valid", 64'(sts_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("desc_ready_idle", 64'(desc_ready), 64'd1);

        // Single full burst, plus desc-to-cmd latency.
        expectCmd(32'h0000_1000, 8'd15);
        expectSts(24'd64, 1'b0, 1'b0);
        applyStimulus(32'h0000_1000, 24'd64);
        checkOutput("cmd_valid_in_calc", 64'(cmd_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("cmd_valid_2cyc", 64'(cmd_valid), 64'd1);
        serveBurst(16, 0, 0, 0, 32'd0, 8'd0);
        waitStatus(0, 24'd0, 1'b0);

        // 4 KiB split, plus burst_done-to-cmd latency.
        expectCmd(32'h0000_0FF8, 8'd1);
        expectCmd(32'h0000_1000, 8'd5);
        expectSts(24'd32, 1'b0, 1'b0);
        applyStimulus(32'h0000_0FF8, 24'd32);
        serveBurst(2, 0, 0, 0, 32'd0, 8'd0);
        checkOutput("cmd_valid_after_burst", 64'(cmd_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("cmd_valid_next_2cyc", 64'(cmd_valid), 64'd1);
        serveBurst(6, 0, 0, 0, 32'd0, 8'd0);
        waitStatus(0, 24'd0, 1'b0);

        // Packet ends on beat 3 with 2 bytes; remaining beats are pads; no second burst.
        expectCmd(32'h0000_2000, 8'd15);
        expectSts(24'd10, 1'b1, 1'b0);
        applyStimulus(32'h0000_2000, 24'd256);
        serveBurst(16, 3, 2, 0, 32'd0, 8'd0);
        waitStatus(0, 24'd0, 1'b0);
        checkOutput("no_second_cmd", 64'(cmd_valid), 64'd0);

        // Command and status back-pressure.
        expectCmd(32'h0000_4000, 8'd3);
        expectSts(24'd16, 1'b0, 1'b0);
        applyStimulus(32'h0000_4000, 24'd16);
        serveBurst(4, 0, 0, 5, 32'h0000_4000, 8'd3);
        waitStatus(4, 24'd16, 1'b0);

        // Two bursts limited by words remaining, eop on the final wlast beat.
        expectCmd(32'h0000_7000, 8'd15);
        expectCmd(32'h0000_7040, 8'd1);
        expectSts(24'd71, 1'b1, 1'b0);
        applyStimulus(32'h0000_7000, 24'd72);
        serveBurst(16, 0, 0, 0, 32'd0, 8'd0);
        serveBurst(2, 2, 3, 0, 32'd0, 8'd0);
        waitStatus(0, 24'd0, 1'b0);

        // Reset in the middle of a burst, then a fresh descriptor.
        begin
            bit ok;
            expectCmd(32'h0000_5000, 8'd15);
            applyStimulus(32'h0000_5000, 24'd64);
            acceptCmd(0, 32'd0, 8'd0, ok);
            for (int b = 0; b < 3; b++) begin
                beat_done  = ok;
                beat_bytes = 3'd4;
                @(posedge clk);
                #1;
            end
            beat_done  = 1'b0;
            beat_bytes = 3'd0;
            rst_n      = 1'b0;
            #1;
            checkOutput("midrst_desc_ready", 64'(desc_ready), 64'd0);
            checkOutput("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
            checkOutput("midrst_sts_valid", 64'(sts_valid), 64'd0);
            checkOutput("midrst_sts_bytes", 64'(sts_bytes), 64'd0);
            checkOutput("midrst_cmd_addr", 64'(cmd_addr), 64'd0);
            @(posedge clk);
            #1;
            checkOutput("midrst_desc_ready_held", 64'(desc_ready), 64'd0);
            rst_n = 1'b1;
        end
        expectCmd(32'h0000_3000, 8'd3);
        expectSts(24'd16, 1'b0, 1'b0);
        applyStimulus(32'h0000_3000, 24'd16);
        serveBurst(4, 0, 0, 0, 32'd0, 8'd0);
        waitStatus(0, 24'd0, 1'b0);

`ifdef S2MM_BURST_CTRL_DESC_CHECK_EN
        // Misaligned address and zero length are rejected without a command.
        expectSts(24'd0, 1'b0, 1'b1);
        applyStimulus(32'h0000_1002, 24'd16);
        waitStatus(0, 24'd0, 1'b0);
        expectSts(24'd0, 1'b0, 1'b1);
        applyStimulus(32'h0000_6000, 24'd0);
        waitStatus(0, 24'd0, 1'b0);
`else
        // Address LSBs are truncated; a zero length finishes with an empty status.
        expectCmd(32'h0000_1000, 8'd3);
        expectSts(24'd16, 1'b0, 1'b0);
        applyStimulus(32'h0000_1002, 24'd16);
        serveBurst(4, 0, 0, 0, 32'd0, 8'd0);
        waitStatus(0, 24'd0, 1'b0);
        expectSts(24'd0, 1'b0, 1'b0);
        applyStimulus(32'h0000_6000, 24'd0);
        waitStatus(0, 24'd0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("cmd_queue_drained", 64'(expCmdQ.size()), 64'd0);
        checkOutput("sts_queue_drained", 64'(expStsQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
